// File: rtl/gemm_tile_ctrl.sv
// GEMM tile sequencer: walks each output tile through weight preload, compute
// (with next-block weight prefetch), pipeline drain and result readout, for
// N tiles per command, with command handshake, output back-pressure and abort.
module gemm_tile_ctrl #(
  parameter int unsigned BLOCK_SIZE_WIDTH = 6,
  parameter int unsigned TILE_CNT_WIDTH   = 8,
  parameter int unsigned SYS_ARRAY_SIZE   = 32,
  parameter int unsigned SYS_ARRAY_NUM    = 1,
  parameter int unsigned MAC_LATENCY      = 3,
  parameter int unsigned ACC_LATENCY      = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [BLOCK_SIZE_WIDTH-1:0] cfg_k_blocks,
  input  logic [TILE_CNT_WIDTH-1:0]   cfg_n_tiles,
  input  logic                        cfg_acc_keep,
  input  logic                        start_valid,
  output logic                        start_ready,
  input  logic                        abort,
  input  logic                        out_ready,
  output logic                        wt_sel,
  output logic                        load_wt,
  output logic                        load_act,
  output logic                        acc_en,
  output logic                        acc_oen,
  output logic                        acc_clear_en,
  output logic                        output_valid,
  output logic                        r_depend,
  output logic                        w_depend,
  output logic                        busy,
  output logic                        done,
  output logic [TILE_CNT_WIDTH-1:0]   tile_idx
);

  localparam int unsigned S         = SYS_ARRAY_SIZE;
  localparam int unsigned PIPE_LAT  = S + MAC_LATENCY + SYS_ARRAY_NUM - 1;
  localparam int unsigned DRAIN_LEN = PIPE_LAT + ACC_LATENCY;
  localparam int unsigned K_MAX     = (1 << BLOCK_SIZE_WIDTH) - 1;
  // One spare bit so the acc_en window sum (drain count + K*S) cannot wrap.
  localparam int unsigned CNT_W     = $clog2(K_MAX * S + DRAIN_LEN + 1) + 1;

  typedef logic [CNT_W-1:0]            cnt_t;
  typedef logic [BLOCK_SIZE_WIDTH-1:0] k_t;
  typedef logic [TILE_CNT_WIDTH-1:0]   tile_t;

  localparam cnt_t  CNT_ONE  = cnt_t'(1);
  localparam cnt_t  S_C      = cnt_t'(S);
  localparam cnt_t  PIPE_C   = cnt_t'(PIPE_LAT);
  localparam cnt_t  DRAIN_C  = cnt_t'(DRAIN_LEN);
  localparam k_t    K_ONE    = k_t'(1);
  localparam tile_t TILE_ONE = tile_t'(1);

  typedef enum logic [2:0] {
    StIdle,
    StPreload,
    StCompute,
    StDrain,
    StOutput
  } state_e;

  state_e r_state;
  state_e w_state_nxt;
  cnt_t   r_cnt;
  cnt_t   w_cnt_nxt;
  k_t     r_k;
  tile_t  r_n;
  logic   r_keep;
  tile_t  r_tile;
  tile_t  w_tile_nxt;
  logic   r_wt_sel;
  logic   r_in_use;
  logic   r_acc_clear;
  logic   r_done;

  cnt_t   w_ks;
  cnt_t   w_pf_len;
  logic   w_last_tile;
  logic   w_accept;
  logic   w_abort;
  logic   w_tile_end;
  logic   w_last_act;
  logic   w_blk_start;

  assign w_ks        = cnt_t'(r_k) * S_C;
  assign w_pf_len    = w_ks - S_C;
  assign w_last_tile = (r_tile == (r_n - TILE_ONE));

  // Next-state, counter and tile sequencing plus decoded strobes
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + CNT_ONE;
    w_tile_nxt   = r_tile;
    w_accept     = 1'b0;
    w_abort      = 1'b0;
    w_tile_end   = 1'b0;
    w_last_act   = 1'b0;

    start_ready  = 1'b0;
    busy         = 1'b0;
    load_wt      = 1'b0;
    load_act     = 1'b0;
    acc_en       = 1'b0;
    output_valid = 1'b0;

    if ((r_state != StIdle) && abort) begin
      w_state_nxt = StIdle;
      w_cnt_nxt   = '0;
      w_tile_nxt  = '0;
      w_abort     = 1'b1;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_cnt_nxt = '0;
          // Abort coincident with a start drops the command.
          if (start_valid && !abort) begin
            w_accept    = 1'b1;
            w_state_nxt = StPreload;
            w_tile_nxt  = '0;
          end
        end
        StPreload: begin
          if (r_cnt == (S_C - CNT_ONE)) begin
            w_state_nxt = StCompute;
            w_cnt_nxt   = '0;
          end
        end
        StCompute: begin
          if (r_cnt == (w_ks - CNT_ONE)) begin
            w_state_nxt = StDrain;
            w_cnt_nxt   = '0;
            w_last_act  = w_last_tile;
          end
        end
        StDrain: begin
          if (r_cnt == (DRAIN_C - CNT_ONE)) begin
            w_state_nxt = StOutput;
            w_cnt_nxt   = '0;
          end
        end
        StOutput: begin
          // The counter here is the beat count; it holds while out_ready is low.
          w_cnt_nxt = r_cnt;
          if (out_ready) begin
            if (r_cnt == (S_C - CNT_ONE)) begin
              w_tile_end = 1'b1;
              w_cnt_nxt  = '0;
              if (w_last_tile) begin
                w_state_nxt = StIdle;
                w_tile_nxt  = '0;
              end else begin
                w_state_nxt = StPreload;
                w_tile_nxt  = r_tile + TILE_ONE;
              end
            end else begin
              w_cnt_nxt = r_cnt + CNT_ONE;
            end
          end
        end
        default: begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = '0;
          w_tile_nxt  = '0;
        end
      endcase
    end

    start_ready  = (r_state == StIdle);
    busy         = (r_state != StIdle);
    // Preload block followed by K-1 prefetch blocks inside compute.
    load_wt      = (r_state == StPreload) ||
                   ((r_state == StCompute) && (r_cnt < w_pf_len));
    load_act     = (r_state == StCompute);
    // load_act delayed by PIPE_LAT: window spans the compute/drain boundary.
    acc_en       = ((r_state == StCompute) && (r_cnt >= PIPE_C)) ||
                   ((r_state == StDrain) && (r_cnt < PIPE_C) &&
                    ((r_cnt + w_ks) >= PIPE_C));
    output_valid = (r_state == StOutput);
  end

  // A new weight block starts on preload entry and on each prefetch boundary.
  assign w_blk_start = ((w_state_nxt == StPreload) && (w_cnt_nxt == '0)) ||
                       ((w_state_nxt == StCompute) && ((w_cnt_nxt & (S_C - CNT_ONE)) == '0) &&
                        (w_cnt_nxt < w_pf_len));

  assign acc_oen      = output_valid & out_ready;
  assign w_depend     = output_valid;
  assign r_depend     = r_in_use;
  assign acc_clear_en = r_acc_clear;
  assign done         = r_done;
  assign wt_sel       = r_wt_sel;
  assign tile_idx     = r_tile;

  // State register and in-state cycle counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Command configuration captured on accept; zero counts run as one
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_k    <= K_ONE;
      r_n    <= TILE_ONE;
      r_keep <= 1'b0;
    end else if (w_accept) begin
      r_k    <= (cfg_k_blocks == '0) ? K_ONE : cfg_k_blocks;
      r_n    <= (cfg_n_tiles == '0) ? TILE_ONE : cfg_n_tiles;
      r_keep <= cfg_acc_keep;
    end
  end

  // Tile index; returns to zero whenever the controller goes idle
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tile <= '0;
    end else begin
      r_tile <= w_tile_nxt;
    end
  end

  // Weight bank select; deliberately carried across tiles and commands
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wt_sel <= 1'b0;
    end else if (w_blk_start) begin
      r_wt_sel <= ~r_wt_sel;
    end
  end

  // Input buffers held from accept until the last activation load of the command
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_in_use <= 1'b0;
    end else if (w_accept) begin
      r_in_use <= 1'b1;
    end else if (w_abort || w_last_act) begin
      r_in_use <= 1'b0;
    end
  end

  // One-cycle clear and completion pulses following the last beat or an abort
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc_clear <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_acc_clear <= w_abort || (w_tile_end && !r_keep);
      r_done      <= w_tile_end && w_last_tile;
    end
  end

endmodule

// File: tb/tb_gemm_tile_ctrl.sv
// Bench for gemm_tile_ctrl: a timeline model derived from tile-relative cycle
// arithmetic checks every output each cycle; directed scenarios pin key
// event cycles to hand-computed constants.
module tb_gemm_tile_ctrl;

  localparam int S     = 32;
  localparam int PIPE  = 35;
  localparam int DRAIN = 37;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] cfg_k_blocks = '0;
  logic [7:0] cfg_n_tiles = '0;
  logic       cfg_acc_keep = 1'b0;
  logic       start_valid = 1'b0;
  logic       abort = 1'b0;
  logic       out_ready = 1'b1;
  logic       start_ready, wt_sel, load_wt, load_act, acc_en, acc_oen, acc_clear_en;
  logic       output_valid, r_depend, w_depend, busy, done;
  logic [7:0] tile_idx;

  always #5 clk = ~clk;

  gemm_tile_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_k_blocks (cfg_k_blocks),
    .cfg_n_tiles  (cfg_n_tiles),
    .cfg_acc_keep (cfg_acc_keep),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .abort        (abort),
    .out_ready    (out_ready),
    .wt_sel       (wt_sel),
    .load_wt      (load_wt),
    .load_act     (load_act),
    .acc_en       (acc_en),
    .acc_oen      (acc_oen),
    .acc_clear_en (acc_clear_en),
    .output_valid (output_valid),
    .r_depend     (r_depend),
    .w_depend     (w_depend),
    .busy         (busy),
    .done         (done),
    .tile_idx     (tile_idx)
  );

  int n_tests = 0;
  int n_fail = 0;
  int g_cyc = 0;

  // Model state: command timeline in absolute cycle numbers
  bit m_live = 0, m_busy = 0, m_keep = 0, m_wt = 0, m_clr_p = 0, m_done_p = 0;
  int m_k = 1, m_n = 1, m_tile = 0, m_ts = 0, m_beats = 0, m_acc_cyc = 0;

  // Observed DUT events, relative to the latest accept
  int s_lwt_n, s_lwt_first, s_lwt_last, s_act_first, s_act_last, s_acc_first, s_acc_last;
  int s_ov_first, s_ov_last, s_ov_n, s_oen_n, s_stall_n, s_clr_n, s_done_n, s_done_rel;
  int s_rdep_fall, s_overlap, s_wt_n, s_wt_t0, s_wt_t1;
  bit p_rdep = 0, p_wt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    s_lwt_n = 0; s_lwt_first = -1; s_lwt_last = -1;
    s_act_first = -1; s_act_last = -1; s_acc_first = -1; s_acc_last = -1;
    s_ov_first = -1; s_ov_last = -1; s_ov_n = 0; s_oen_n = 0; s_stall_n = 0;
    s_clr_n = 0; s_done_n = 0; s_done_rel = -1; s_rdep_fall = -1; s_overlap = 0;
    s_wt_n = 0; s_wt_t0 = -1; s_wt_t1 = -1;
  endtask

  task automatic monitor();
    logic [19:0] v_exp, v_act;
    logic [7:0]  e_tile;
    bit e_lwt, e_act, e_acc, e_ov, e_rdep;
    int rel, rel_a, ks;
    forever begin
      @(negedge clk);
      ks = m_k * S;
      rel = g_cyc - m_ts;
      e_lwt = 0; e_act = 0; e_acc = 0; e_ov = 0; e_rdep = 0;
      if (m_busy) begin
        e_lwt  = rel < ks;
        e_act  = (rel >= S) && (rel < S + ks);
        e_acc  = (rel >= S + PIPE) && (rel < S + ks + PIPE);
        e_ov   = rel >= S + ks + DRAIN;
        e_rdep = !((m_tile == m_n - 1) && (rel >= S + ks));
        if ((rel % S == 0) && (rel < ks)) m_wt = ~m_wt;
      end
      e_tile = m_busy ? 8'(m_tile) : 8'd0;
      if (m_live) begin
        v_exp = {!m_busy, m_wt, e_lwt, e_act, e_acc, e_ov && out_ready, m_clr_p, e_ov,
                 e_rdep, e_ov, m_busy, m_done_p, e_tile};
        v_act = {start_ready, wt_sel, load_wt, load_act, acc_en, acc_oen, acc_clear_en,
                 output_valid, r_depend, w_depend, busy, done, tile_idx};
        n_tests++;
        if (v_act !== v_exp) begin
          n_fail++;
          $display("FAIL cycle %0d outputs: got %b, expected %b", g_cyc, v_act, v_exp);
        end
        rel_a = g_cyc - m_acc_cyc;
        if (load_wt) begin
          s_lwt_n++; if (s_lwt_first < 0) s_lwt_first = rel_a; s_lwt_last = rel_a;
        end
        if (load_act) begin
          if (s_act_first < 0) s_act_first = rel_a; s_act_last = rel_a;
        end
        if (acc_en) begin
          if (s_acc_first < 0) s_acc_first = rel_a; s_acc_last = rel_a;
        end
        if (output_valid) begin
          s_ov_n++; if (s_ov_first < 0) s_ov_first = rel_a; s_ov_last = rel_a;
        end
        if (load_wt && load_act) s_overlap++;
        if (acc_oen) s_oen_n++;
        if (output_valid && !acc_oen) s_stall_n++;
        if (acc_clear_en) s_clr_n++;
        if (done) begin s_done_n++; s_done_rel = rel_a; end
        if (p_rdep && !r_depend && s_rdep_fall < 0) s_rdep_fall = rel_a;
        if (wt_sel != p_wt) begin
          if (s_wt_n == 0) s_wt_t0 = rel_a;
          else if (s_wt_n == 1) s_wt_t1 = rel_a;
          s_wt_n++;
        end
        p_rdep = r_depend;
        p_wt = wt_sel;
      end
      // Advance the model using this cycle's inputs
      m_clr_p = 0;
      m_done_p = 0;
      if (!reset) begin
        m_live = 1; m_busy = 0; m_wt = 0; m_tile = 0;
      end else if (m_live) begin
        if (m_busy && abort) begin
          m_busy = 0; m_clr_p = 1; m_tile = 0;
        end else if (!m_busy) begin
          if (start_valid && !abort) begin
            m_busy = 1;
            m_k = (cfg_k_blocks == 0) ? 1 : int'(cfg_k_blocks);
            m_n = (cfg_n_tiles == 0) ? 1 : int'(cfg_n_tiles);
            m_keep = cfg_acc_keep;
            m_tile = 0; m_ts = g_cyc + 1; m_beats = 0; m_acc_cyc = g_cyc;
            clear_stats();
          end
        end else if (e_ov && out_ready) begin
          m_beats++;
          if (m_beats == S) begin
            m_clr_p = !m_keep;
            if (m_tile == m_n - 1) begin
              m_busy = 0; m_done_p = 1; m_tile = 0;
            end else begin
              m_tile++; m_ts = g_cyc + 1; m_beats = 0;
            end
          end
        end
      end
      g_cyc++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (g_cyc < c) step();
  endtask

  task automatic start_cmd(input int k, input int n, input bit keep);
    cfg_k_blocks = 6'(k);
    cfg_n_tiles = 8'(n);
    cfg_acc_keep = keep;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (done) seen = 1;
    end
    chk(name, int'(seen), 1);
    repeat (2) step();
  endtask

  int a;

  initial begin
    clear_stats();
    fork
      monitor();
    join_none
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("reset start_ready", int'(start_ready), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset wt_sel", int'(wt_sel), 0);
    chk("reset tile_idx", int'(tile_idx), 0);

    // Single tile, K=2
    start_cmd(2, 1, 0);
    wait_done(400, "s1 done seen");
    chk("s1 load_wt first", s_lwt_first, 1);
    chk("s1 load_wt last", s_lwt_last, 64);
    chk("s1 load_wt count", s_lwt_n, 64);
    chk("s1 wt_sel toggle0", s_wt_t0, 1);
    chk("s1 wt_sel toggle1", s_wt_t1, 33);
    chk("s1 load_act first", s_act_first, 33);
    chk("s1 load_act last", s_act_last, 96);
    chk("s1 acc_en first", s_acc_first, 68);
    chk("s1 acc_en last", s_acc_last, 131);
    chk("s1 output_valid first", s_ov_first, 134);
    chk("s1 output_valid last", s_ov_last, 165);
    chk("s1 done cycle", s_done_rel, 166);
    chk("s1 clear count", s_clr_n, 1);
    chk("s1 r_depend fall", s_rdep_fall, 97);
    repeat (3) step();

    // Three tiles, K=1
    start_cmd(1, 3, 0);
    wait_done(800, "s2 done seen");
    chk("s2 done cycle", s_done_rel, 400);
    chk("s2 clear count", s_clr_n, 3);
    chk("s2 done count", s_done_n, 1);
    chk("s2 wt/act overlap", s_overlap, 0);
    chk("s2 r_depend fall", s_rdep_fall, 331);
    chk("s2 wt_sel toggles", s_wt_n, 3);
    chk("s2 beats", s_oen_n, 96);
    repeat (3) step();

    // Back-pressure for 10 cycles mid-output
    start_cmd(1, 1, 0);
    a = m_acc_cyc;
    wait_until(a + 110);
    out_ready = 1'b0;
    wait_until(a + 120);
    out_ready = 1'b1;
    wait_done(400, "s3 done seen");
    chk("s3 beats", s_oen_n, 32);
    chk("s3 valid cycles", s_ov_n, 42);
    chk("s3 stall cycles", s_stall_n, 10);
    chk("s3 done cycle", s_done_rel, 144);
    repeat (3) step();

    // Abort in compute, then an immediate new command
    start_cmd(2, 1, 0);
    a = m_acc_cyc;
    wait_until(a + 40);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("s4 abort busy", int'(busy), 0);
    chk("s4 abort start_ready", int'(start_ready), 1);
    chk("s4 abort clear", int'(acc_clear_en), 1);
    chk("s4 abort done", int'(done), 0);
    chk("s4 abort r_depend", int'(r_depend), 0);
    start_cmd(1, 1, 0);
    chk("s4 restart busy", int'(busy), 1);
    wait_done(400, "s4 done seen");
    chk("s4 restart done cycle", s_done_rel, 134);
    chk("s4 restart clear count", s_clr_n, 1);
    repeat (3) step();

    // Abort on the same cycle as a start drops the command
    cfg_k_blocks = 6'd1;
    cfg_n_tiles = 8'd1;
    start_valid = 1'b1;
    abort = 1'b1;
    step();
    start_valid = 1'b0;
    abort = 1'b0;
    chk("s4b dropped busy", int'(busy), 0);
    chk("s4b dropped clear", int'(acc_clear_en), 0);
    step();
    chk("s4b still idle", int'(start_ready), 1);

    // Keep mode with zero counts
    start_cmd(0, 0, 1);
    wait_done(400, "s5 done seen");
    chk("s5 done cycle", s_done_rel, 134);
    chk("s5 clear count", s_clr_n, 0);
    chk("s5 done count", s_done_n, 1);
    chk("s5 load_wt count", s_lwt_n, 32);
    repeat (3) step();

    // Reset mid-drain with start_valid held
    start_cmd(1, 1, 0);
    a = m_acc_cyc;
    wait_until(a + 70);
    reset = 1'b0;
    start_valid = 1'b1;
    step();
    chk("s6 reset start_ready", int'(start_ready), 1);
    chk("s6 reset outputs", int'({wt_sel, load_wt, load_act, acc_en, acc_oen, acc_clear_en,
                                  output_valid, r_depend, w_depend, busy, done, tile_idx}), 0);
    wait_until(a + 73);
    reset = 1'b1;
    chk("s6 no accept in reset", int'(busy), 0);
    step();
    start_valid = 1'b0;
    chk("s6 accept after reset", int'(busy), 1);
    wait_done(400, "s6 done seen");
    chk("s6 done cycle", s_done_rel, 134);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
